// File: rtl/instr_fetch_if.sv
// Load port and instruction-issue handshake between the fetch unit and its neighbours.
// The slave modport is the fetch unit's view; the master modport is the driver/consumer view.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 16
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              instr_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] address;
    logic              halted;
    logic              load_err;

    modport master (
        output load_en, load_addr, load_data, start, instr_ready,
        input  instr_valid, instruction, address, halted, load_err
    );

    modport slave (
        input  load_en, load_addr, load_data, start, instr_ready,
        output instr_valid, instruction, address, halted, load_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-supply stage: writable store, PC stepped every TICK_DIV cycles,
// one instruction per step over valid/ready, stops after delivering HALT_OP.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TICK_DIV = 50000000,
    parameter logic [3:0]  HALT_OP  = 4'b1110
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ISSUE, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == TICK_LAST) state_d = S_ISSUE;
            S_ISSUE: begin
                if (valid_q && bus.instr_ready)
                    state_d = (instr_q[DATA_W-1 -: 4] == HALT_OP) ? S_HALT : S_RUN;
            end
            S_HALT:  if (bus.start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the datapath registers; stores are only accepted in IDLE
    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        halted_d = halted_q;
        mem_we   = bus.load_en && (state_q == S_IDLE);
        err_d    = err_q | (bus.load_en && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d  = '0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                if (cnt_q == TICK_LAST) begin
                    instr_d = mem_q[pc_q];
                    addr_d  = pc_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (valid_q && bus.instr_ready) begin
                    valid_d = 1'b0;
                    if (instr_q[DATA_W-1 -: 4] == HALT_OP) halted_d = 1'b1;
                    else                                   pc_d = pc_q + ADDR_W'(1);
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    halted_d = 1'b0;
                    pc_d     = '0;
                    cnt_d    = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            addr_q   <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Instruction store, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.instr_valid = valid_q;
    assign bus.instruction = instr_q;
    assign bus.address     = addr_q;
    assign bus.halted      = halted_q;
    assign bus.load_err    = err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (TICK_DIV=4 and TICK_DIV=1) share stimulus and
// are checked every cycle against a schedule-based model, plus directed literal expectations.
module tb_instr_fetch_unit;
    localparam int TD0 = 4;
    localparam int TD1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic        start = 1'b0;
    logic        ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int n;

    instr_fetch_if #(.ADDR_W(3), .DATA_W(16)) b4 ();
    instr_fetch_if #(.ADDR_W(3), .DATA_W(16)) b1 ();

    assign b4.load_en = load_en;  assign b1.load_en = load_en;
    assign b4.load_addr = load_addr;  assign b1.load_addr = load_addr;
    assign b4.load_data = load_data;  assign b1.load_data = load_data;
    assign b4.start = start;  assign b1.start = start;
    assign b4.instr_ready = ready;  assign b1.instr_ready = ready;

    instr_fetch_unit #(.ADDR_W(3), .DATA_W(16), .TICK_DIV(TD0), .HALT_OP(4'b1110)) u4 (
        .clk(clk), .rst(rst), .bus(b4));
    instr_fetch_unit #(.ADDR_W(3), .DATA_W(16), .TICK_DIV(TD1), .HALT_OP(4'b1110)) u1 (
        .clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    logic        o_valid [2];
    logic [15:0] o_instr [2];
    logic [2:0]  o_addr  [2];
    logic        o_halt  [2];
    logic        o_err   [2];
    assign o_valid[0] = b4.instr_valid;  assign o_valid[1] = b1.instr_valid;
    assign o_instr[0] = b4.instruction;  assign o_instr[1] = b1.instruction;
    assign o_addr[0]  = b4.address;      assign o_addr[1]  = b1.address;
    assign o_halt[0]  = b4.halted;       assign o_halt[1]  = b1.halted;
    assign o_err[0]   = b4.load_err;     assign o_err[1]   = b1.load_err;

    // Model: mode 0=idle, 1=waiting for fetch edge 'due', 2=presenting, 3=halted
    int          cyc;
    int          mode [2];
    int          due  [2];
    int          mpc  [2];
    logic [15:0] ms   [2][8];
    logic        mvalid [2];
    logic [15:0] minstr [2];
    logic [2:0]  maddr  [2];
    logic        mhalt  [2];
    logic        merr   [2];

    function automatic int tdiv(input int k);
        return (k == 0) ? TD0 : TD1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; due[k] = 0; mpc[k] = 0;
            mvalid[k] = 1'b0; minstr[k] = '0; maddr[k] = '0;
            mhalt[k] = 1'b0; merr[k] = 1'b0;
            for (int a = 0; a < 8; a++) ms[k][a] = '0;
        end
    endtask

    task automatic model_step();
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (load_en) begin
                if (mode[k] == 0) ms[k][load_addr] = load_data;
                else              merr[k] = 1'b1;
            end
            case (mode[k])
                0, 3: if (start) begin
                    mode[k] = 1; mpc[k] = 0; mhalt[k] = 1'b0; due[k] = cyc + tdiv(k);
                end
                1: if (cyc == due[k]) begin
                    mode[k] = 2; mvalid[k] = 1'b1;
                    minstr[k] = ms[k][mpc[k]]; maddr[k] = 3'(mpc[k]);
                end
                2: if (ready) begin
                    mvalid[k] = 1'b0;
                    if (minstr[k][15:12] == 4'hE) begin
                        mode[k] = 3; mhalt[k] = 1'b1;
                    end else begin
                        mpc[k] = (mpc[k] + 1) % 8; mode[k] = 1; due[k] = cyc + tdiv(k);
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("m%0d_valid", k), 32'(o_valid[k]), 32'(mvalid[k]));
                    chk($sformatf("m%0d_halted", k), 32'(o_halt[k]), 32'(mhalt[k]));
                    chk($sformatf("m%0d_load_err", k), 32'(o_err[k]), 32'(merr[k]));
                    if (mvalid[k]) begin
                        chk($sformatf("m%0d_instr", k), 32'(o_instr[k]), 32'(minstr[k]));
                        chk($sformatf("m%0d_addr", k), 32'(o_addr[k]), 32'(maddr[k]));
                    end
                end
            end
        end
    end

    task automatic tick(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; load_en = 1'b0; start = 1'b0; ready = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick(1);
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("reset_valid", 32'(b4.instr_valid), 32'd0);
        chk("reset_halted", 32'(b4.halted), 32'd0);
        chk("reset_err", 32'(b4.load_err), 32'd0);

        // Load and run, TICK_DIV=4
        do_reset();
        load(3'd0, 16'h1105); load(3'd1, 16'h2240); load(3'd2, 16'hE000);
        ready = 1'b1;
        pulse_start();
        tick(3);
        chk("run_valid_early", 32'(b4.instr_valid), 32'd0);
        tick(1);
        chk("run_v0", 32'(b4.instr_valid), 32'd1);
        chk("run_a0", 32'(b4.address), 32'd0);
        chk("run_i0", 32'(b4.instruction), 32'h1105);
        tick(5);
        chk("run_a1", 32'(b4.address), 32'd1);
        chk("run_i1", 32'(b4.instruction), 32'h2240);
        tick(5);
        chk("run_i2", 32'(b4.instruction), 32'hE000);
        chk("run_halt_pre", 32'(b4.halted), 32'd0);
        tick(1);
        chk("run_halted", 32'(b4.halted), 32'd1);
        tick(10);
        chk("run_no_more_valid", 32'(b4.instr_valid), 32'd0);

        // Wrap-around, TICK_DIV=1
        do_reset();
        for (int i = 0; i < 8; i++) load(3'(i), 16'h0100 + 16'(i));
        ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("wrap_valid_hi", 32'(b1.instr_valid), 32'd1);
            chk("wrap_addr", 32'(b1.address), 32'(i % 8));
            chk("wrap_instr", 32'(b1.instruction), 32'h0100 + 32'(i % 8));
            tick(1);
            chk("wrap_valid_lo", 32'(b1.instr_valid), 32'd0);
        end

        // Backpressure, TICK_DIV=4
        do_reset();
        load(3'd0, 16'h1001); load(3'd1, 16'h1002); load(3'd2, 16'h1003); load(3'd3, 16'h1004);
        pulse_start();
        tick(4);
        chk("bp_valid", 32'(b4.instr_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk("bp_hold_valid", 32'(b4.instr_valid), 32'd1);
            chk("bp_hold_addr", 32'(b4.address), 32'd0);
            chk("bp_hold_instr", 32'(b4.instruction), 32'h1001);
        end
        ready = 1'b1;
        tick(1);
        chk("bp_taken", 32'(b4.instr_valid), 32'd0);
        tick(4);
        chk("bp_next_addr", 32'(b4.address), 32'd1);
        chk("bp_next_instr", 32'(b4.instruction), 32'h1002);

        // Load attempted while running is dropped and flagged
        tick(1);
        load_en = 1'b1; load_addr = 3'd3; load_data = 16'hFFFF;
        tick(1);
        load_en = 1'b0;
        chk("lerr_set", 32'(b4.load_err), 32'd1);
        n = 0;
        while (!(b4.instr_valid && b4.address == 3'd3) && n < 100) begin
            tick(1); n++;
        end
        chk("lerr_wait_addr3", 32'(n < 100), 32'd1);
        chk("lerr_store_kept", 32'(b4.instruction), 32'h1004);
        chk("lerr_sticky", 32'(b4.load_err), 32'd1);

        // Simultaneous load+start, then restart from HALT
        do_reset();
        load(3'd1, 16'hE000);
        ready = 1'b1;
        load_en = 1'b1; load_addr = 3'd0; load_data = 16'h1ABC; start = 1'b1;
        tick(1);
        load_en = 1'b0; start = 1'b0;
        tick(4);
        chk("sim_v0", 32'(b4.instr_valid), 32'd1);
        chk("sim_i0", 32'(b4.instruction), 32'h1ABC);
        n = 0;
        while (!b4.halted && n < 100) begin
            tick(1); n++;
        end
        chk("sim_wait_halt", 32'(n < 100), 32'd1);
        chk("sim_err_clear", 32'(b4.load_err), 32'd0);
        ready = 1'b0;
        pulse_start();
        chk("restart_halted_lo", 32'(b4.halted), 32'd0);
        tick(4);
        chk("restart_valid", 32'(b4.instr_valid), 32'd1);
        chk("restart_addr", 32'(b4.address), 32'd0);
        chk("restart_instr", 32'(b4.instruction), 32'h1ABC);

        // Asynchronous reset in the middle of ISSUE
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(b4.instr_valid), 32'd0);
        chk("arst_addr", 32'(b4.address), 32'd0);
        chk("arst_instr", 32'(b4.instruction), 32'd0);
        chk("arst_halted", 32'(b1.halted), 32'd0);
        tick(1);
        rst = 1'b0;
        ready = 1'b1;
        pulse_start();
        tick(4);
        chk("arst_store_valid", 32'(b4.instr_valid), 32'd1);
        chk("arst_store_zero", 32'(b4.instruction), 32'd0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
